// File: rtl/key_pkg.sv
// Shared types and elaboration helpers for the matrix keypad scanner and its tick generator.
package key_pkg;

    // IDLE: wait for any key | DEB_PRESS: qualify press | SCAN: find column | HOLD: key down | DEB_REL: qualify release
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB_PRESS,
        ST_SCAN,
        ST_HOLD,
        ST_DEB_REL
    } state_t;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    function automatic int ms_to_ticks(input int ms, input int scan_hz);
        int t;
        t = ms * scan_hz / 1000;
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running 1-clk enable pulse every DIV clocks; shared by low-rate scanners.
module scan_tick_gen
    import key_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = clog2(DIV);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == '0) begin
            r_cnt <= CW'(DIV - 1);
        end else begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/matrix_key_scan.sv
// ROWS x COLS keypad scanner: debounce, column scan, valid/ready event output with overflow.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module matrix_key_scan
    import key_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int CLK_HZ          = 50_000_000,
    parameter int SCAN_HZ         = 1000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    localparam int CODE_W         = clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overflow
);

    localparam int TICK_DIV  = (CLK_HZ / SCAN_HZ < 1) ? 1 : CLK_HZ / SCAN_HZ;
    localparam int DEB_TICKS = ms_to_ticks(DEBOUNCE_MS, SCAN_HZ);
    localparam int DEB_W     = clog2(DEB_TICKS + 1);
    localparam int CIDX_W    = clog2(COLS);

    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 ||
        REPEAT_DELAY_MS < 0 || REPEAT_RATE_MS < 0) begin : g_param_check
        $error("matrix_key_scan: unsupported parameter set");
    end

    logic              w_tick;
    logic [ROWS-1:0]   r_row_meta;
    logic [ROWS-1:0]   r_row_sync;
    logic              w_pressed;
    int                w_hit_row;
    logic [CODE_W-1:0] w_hit_code;

    state_t            r_state;
    state_t            w_state_nx;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [DEB_W-1:0]  w_deb_nx;
    logic [CIDX_W-1:0] r_col_idx;
    logic [CIDX_W-1:0] w_cidx_nx;
    logic [COLS-1:0]   r_col;
    logic [COLS-1:0]   w_col_nx;
    logic              w_post;

    logic              w_ev_post;
    logic [CODE_W-1:0] w_ev_code;
    logic              w_handshake;
    logic              r_key_valid;
    logic [CODE_W-1:0] r_key_code;
    logic              r_overflow;

    scan_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= row;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_pressed = (r_row_sync != '1);

    // Lowest low row wins when several rows are closed on the same column.
    always_comb begin
        w_hit_row = 0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!r_row_sync[i]) w_hit_row = i;
        end
    end

    assign w_hit_code = CODE_W'(w_hit_row * COLS + int'(r_col_idx));

    always_comb begin
        w_state_nx = r_state;
        w_deb_nx   = r_deb_cnt;
        w_cidx_nx  = r_col_idx;
        w_post     = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pressed) begin
                        w_deb_nx   = DEB_W'(1);
                        w_state_nx = ST_DEB_PRESS;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!w_pressed) begin
                        w_deb_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end else if (int'(r_deb_cnt) >= DEB_TICKS - 1) begin
                        w_deb_nx   = '0;
                        w_cidx_nx  = '0;
                        w_state_nx = ST_SCAN;
                    end else begin
                        w_deb_nx = r_deb_cnt + DEB_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (w_pressed) begin
                        w_post     = 1'b1;
                        w_cidx_nx  = '0;
                        w_state_nx = ST_HOLD;
                    end else if (int'(r_col_idx) == COLS - 1) begin
                        w_cidx_nx  = '0;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_cidx_nx = r_col_idx + CIDX_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!w_pressed) begin
                        w_deb_nx   = DEB_W'(1);
                        w_state_nx = ST_DEB_REL;
                    end
                end
                ST_DEB_REL: begin
                    if (w_pressed) begin
                        w_deb_nx   = '0;
                        w_state_nx = ST_HOLD;
                    end else if (int'(r_deb_cnt) >= DEB_TICKS - 1) begin
                        w_deb_nx   = '0;
                        w_state_nx = ST_IDLE;
                    end else begin
                        w_deb_nx = r_deb_cnt + DEB_W'(1);
                    end
                end
                default: begin
                    w_deb_nx   = '0;
                    w_cidx_nx  = '0;
                    w_state_nx = ST_IDLE;
                end
            endcase
        end
        w_col_nx = (w_state_nx == ST_SCAN) ? ~(COLS'(1) << w_cidx_nx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
            r_col_idx <= '0;
            r_col     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_deb_cnt <= w_deb_nx;
            r_col_idx <= w_cidx_nx;
            r_col     <= w_col_nx;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_DELAY = ms_to_ticks(REPEAT_DELAY_MS, SCAN_HZ);
    localparam int REP_RATE  = ms_to_ticks(REPEAT_RATE_MS, SCAN_HZ);
    localparam int REP_W     = clog2(((REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE) + 1);

    logic [REP_W-1:0]  r_rep_cnt;
    logic [CODE_W-1:0] r_held_code;
    logic              w_rep_tick;
    logic              w_rep_post;

    assign w_rep_tick = (r_state == ST_HOLD) && w_tick && w_pressed;
    assign w_rep_post = w_rep_tick && (r_rep_cnt == '0);

    // Counter only advances in HOLD, so a release bounce pauses it rather than restarting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= '0;
            r_held_code <= '0;
        end else if (w_post) begin
            r_rep_cnt   <= REP_W'(REP_DELAY - 1);
            r_held_code <= w_hit_code;
        end else if (w_rep_tick) begin
            r_rep_cnt <= (r_rep_cnt == '0) ? REP_W'(REP_RATE - 1) : r_rep_cnt - REP_W'(1);
        end else if (w_state_nx == ST_IDLE) begin
            r_rep_cnt <= '0;
        end
    end

    assign w_ev_post = w_post | w_rep_post;
    assign w_ev_code = w_post ? w_hit_code : r_held_code;
`else
    assign w_ev_post = w_post;
    assign w_ev_code = w_hit_code;
`endif

    assign w_handshake = r_key_valid && key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (w_ev_post && (!r_key_valid || w_handshake)) begin
                r_key_valid <= 1'b1;
                r_key_code  <= w_ev_code;
            end else if (w_ev_post) begin
                r_overflow <= 1'b1;
            end else if (w_handshake) begin
                r_key_valid <= 1'b0;
            end
        end
    end

    assign col       = r_col;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign overflow  = r_overflow;
    assign key_held  = (r_state == ST_HOLD) || (r_state == ST_DEB_REL);

endmodule

// File: doc/matrix_key_scan.md
Name: matrix_key_scan

Overview:
Parametrised ROWS x COLS matrix-keypad scanner for the board-level input path. It is the successor to the fixed 4x4 scanner. It runs entirely in the system clock domain, using a scan-tick enable instead of a derived clock. It debounces press and release, resolves the key to a linear code and delivers it on a valid/ready event interface with overflow reporting. Consumers are the UI/controller blocks that previously polled flag/data.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of column outputs (2..8)
CLK_HZ, 50_000_000, clk frequency in Hz
SCAN_HZ, 1000, scan tick rate in Hz; TICK_DIV = CLK_HZ/SCAN_HZ
DEBOUNCE_MS, 20, press/release stable time; DEB_TICKS = DEBOUNCE_MS*SCAN_HZ/1000 (min 1)
REPEAT_DELAY_MS, 500, first auto-repeat delay (used only with KEY_REPEAT_EN)
REPEAT_RATE_MS, 100, auto-repeat period (used only with KEY_REPEAT_EN)
CODE_W, clog2(ROWS*COLS), key code width (derived, localparam)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
row  in  ROWS  row lines, active-low (pulled up; 0 = key closed on driven column)
col  out  COLS  column drives, active-low
key_valid  out  1  event available
key_code  out  CODE_W  key code = row_idx*COLS + col_idx
key_ready  in  1  consumer accepts event when key_valid && key_ready
key_held  out  1  a debounced key is currently down
overflow  out  1  one-clk pulse: event dropped because previous one was not consumed

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All flops reset asynchronously.
- Reset values: col = all 0, key_valid = 0, key_code = 0, key_held = 0, overflow = 0, FSM = IDLE, all counters = 0. Reset mid-scan or mid-event discards everything, including any pending event.
- row passes through a 2-flop synchroniser. pressed = (row_sync != all-ones).
- Tick: 1-clk pulse every TICK_DIV clocks, free-running from reset. All FSM transitions except event output occur on tick cycles.
- IDLE: col = all 0. If pressed on a tick, deb_cnt = 1 and go to DEB_PRESS.
- DEB_PRESS:
  - Each tick with pressed: deb_cnt++.
  - Any tick with not pressed: deb_cnt = 0 and return to IDLE.
  - When deb_cnt reaches DEB_TICKS: go to SCAN with col_idx = 0 and col = ~(1<<0).
- SCAN: on each tick, sample row_sync.
  - If any bit is low: capture code using the lowest low row index and the current col_idx, then go to HOLD with col = all 0.
  - Otherwise col_idx++ and drive the next column.
  - After col_idx = COLS-1 with no hit: go to IDLE (bounce or released); no event.
- Event output: on SCAN->HOLD the code is posted.
  - If key_valid = 0: key_code <= code and key_valid <= 1 on the next clk.
  - If key_valid = 1 and no handshake this cycle: the new code is dropped and overflow pulses for 1 clk.
  - If a handshake occurs in the same cycle: the new code is loaded and key_valid stays 1.
  - key_valid clears the clk after key_valid && key_ready unless reloaded. key_code is stable while key_valid = 1.
- HOLD: key_held = 1, col = all 0. A tick with not pressed sets deb_cnt = 1 and goes to DEB_REL.
- DEB_REL: key_held = 1.
  - Tick with not pressed: deb_cnt++.
  - Tick with pressed: return to HOLD; no new event.
  - At deb_cnt = DEB_TICKS: go to IDLE, key_held = 0.
- Multiple simultaneous keys: only the first hit in scan order (column ascending, then row ascending) is reported. No further event until full release.
- Latency: press-stable to key_valid is DEB_TICKS + col_idx + 1 ticks, plus synchroniser and 1 clk.

Optional Feature:
KEY_REPEAT_EN
- Defined: in HOLD, a repeat counter counts ticks. After REPEAT_DELAY_MS*SCAN_HZ/1000 ticks the held code is re-posted, then re-posted every REPEAT_RATE_MS*SCAN_HZ/1000 ticks. Re-posts follow the same overflow rule. The counter clears on leaving HOLD; it keeps counting through DEB_REL->HOLD bounce returns.
- Undefined: exactly one event per press. The repeat counter and its parameters are unused and produce no logic.

Decomposition:
- Shared package key_pkg:
  - FSM state encoding (IDLE, DEB_PRESS, SCAN, HOLD, DEB_REL)
  - clog2 function
  - ms-to-ticks helper function
- One sub-module, scan_tick_gen (param DIV): outputs the 1-clk tick pulse. It is reusable by other low-rate scanners (LED/7-seg).

Test Plan:
All tests use sim params CLK_HZ=10_000, SCAN_HZ=1000 (tick every 10 clk), DEBOUNCE_MS=3 (DEB_TICKS=3), 4x4.
- Clean press: key at row 2, col 1 held 20 ticks with key_ready=1 -> exactly one key_valid pulse with key_code=9; key_held high until 3 ticks after release.
- Bounce: row toggles low/high every tick for 6 ticks, then stays high -> no key_valid; FSM returns to IDLE; col returns to 0000.
- Backpressure: key_ready=0; press code 0, release, press code 15 -> key_code stays 0; one overflow pulse; after key_ready=1 for one clk, key_valid=0.
- Multi-key: rows 1 and 3 both closed on col 2 -> key_code=6 only; no event until both are released.
- Reset mid-SCAN: assert rst_n=0 while col=1011 -> col=0000, key_valid=0, key_code=0 immediately (asynchronously); after release, a normal press yields a correct code.
- KEY_REPEAT_EN, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=5: hold key 7 for 30 ticks -> events at first post, then +10, +15, +20, +25 ticks, all with key_code=7.
